// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: DEPTH-entry FIFO feeding an output instruction
// register that presents opcode/operand fields under a valid/ready handshake.
module instr_prefetch_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int OPC_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPC_W-1:0]          opcode,
  output logic [DATA_W-OPC_W-1:0]   operand,
  output logic [$clog2(DEPTH+2)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LVL_W = $clog2(DEPTH + 2);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] ir;

  logic push;
  logic load;
  logic fifo_empty;
  logic pop;
  logic bypass;
  logic fifo_wr;

  assign in_ready   = !flush && (fifo_count < DEPTH_C);
  assign push       = in_valid && in_ready;
  assign load       = !out_valid || out_ready;
  assign fifo_empty = (fifo_count == '0);
  assign pop        = load && !fifo_empty;
  // An empty FIFO with a free IR sends the incoming word straight to the IR.
  assign bypass     = load && fifo_empty && push;
  assign fifo_wr    = push && !bypass;

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ir         <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ir         <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_wr, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (load) begin
        if (!fifo_empty) begin
          ir        <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (push) begin
          ir        <= in_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign opcode  = ir[DATA_W-1 -: OPC_W];
  assign operand = ir[DATA_W-OPC_W-1:0];
  assign level   = LVL_W'(fifo_count) + LVL_W'(out_valid);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_instr_prefetch_queue;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int OPC_W  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [OPC_W-1:0] opcode;
  logic [DATA_W-OPC_W-1:0] operand;
  logic [$clog2(DEPTH+2)-1:0] level;

  int checks = 0;
  int errors = 0;

  instr_prefetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OPC_W(OPC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .operand(operand), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of buffered words plus the output register.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_ir;
  bit                m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ir = '0;
      m_v  = 1'b0;
    end else if (flush) begin
      m_q.delete();
      m_ir = '0;
      m_v  = 1'b0;
    end else begin
      bit acc;
      acc = in_valid && (m_q.size() < DEPTH);
      if (!m_v || out_ready) begin
        if (m_q.size() > 0) begin
          m_ir = m_q.pop_front();
          m_v  = 1'b1;
          if (acc) m_q.push_back(in_data);
        end else if (acc) begin
          m_ir = in_data;
          m_v  = 1'b1;
        end else begin
          m_v = 1'b0;
        end
      end else if (acc) begin
        m_q.push_back(in_data);
      end
    end
  end

  bit log_en = 1'b0;
  int got[$];

  always @(negedge clk) begin
    check("out_valid", int'(out_valid), int'(m_v));
    check("opcode", int'(opcode), int'(m_ir[DATA_W-1 -: OPC_W]));
    check("operand", int'(operand), int'(m_ir[DATA_W-OPC_W-1:0]));
    check("level", int'(level), m_q.size() + int'(m_v));
    check("in_ready", int'(in_ready), int'(!flush && (m_q.size() < DEPTH)));
    if (log_en && out_valid && out_ready) got.push_back(int'(opcode));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_opcode", int'(opcode), 0);

    // 1: single push, held with out_ready low
    in_valid = 1'b1; in_data = 8'hA7;
    cyc();
    in_valid = 1'b0;
    check("t1_valid", int'(out_valid), 1);
    check("t1_opcode", int'(opcode), 'hA);
    check("t1_operand", int'(operand), 'h7);
    check("t1_level", int'(level), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t1_hold_opcode", int'(opcode), 'hA);
      check("t1_hold_operand", int'(operand), 'h7);
    end

    // 2: fill to capacity
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'((i + 1) * 16 + i);
      cyc();
    end
    check("t2_level", int'(level), 5);
    check("t2_in_ready", int'(in_ready), 0);
    check("t2_opcode", int'(opcode), 1);

    // 3: drain with producer still offering 0x65
    out_ready = 1'b1; log_en = 1'b1;
    cyc();
    cyc();
    in_valid = 1'b0;
    repeat (6) cyc();
    log_en = 1'b0;
    check("t3_count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check("t3_order", got[i], i + 1);
    end
    check("t3_level", int'(level), 0);

    // 4: continuous stream, one cycle latency
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      cyc();
      check("t4_level", int'(level), 1);
      check("t4_operand", int'(operand), i);
      check("t4_opcode", int'(opcode), 0);
    end
    in_valid = 1'b0;
    cyc();
    check("t4_drain", int'(level), 0);

    // 5: flush with a word offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h81 + 8'h11 * i);
      cyc();
    end
    check("t5_level_pre", int'(level), 3);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    #1;
    check("t5_in_ready_flush", int'(in_ready), 0);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_valid", int'(out_valid), 0);
    check("t5_level", int'(level), 0);
    check("t5_opcode", int'(opcode), 0);
    check("t5_operand", int'(operand), 0);
    cyc();
    check("t5_level_after", int'(level), 0);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hB1 + 8'h11 * i);
      cyc();
    end
    in_valid = 1'b0;
    check("t6_level_pre", int'(level), 4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_level", int'(level), 0);
    check("t6_rst_opcode", int'(opcode), 0);
    check("t6_rst_operand", int'(operand), 0);
    rst_n = 1'b1;
    cyc();
    in_valid = 1'b1; in_data = 8'h3C;
    cyc();
    in_valid = 1'b0;
    check("t6_valid", int'(out_valid), 1);
    check("t6_opcode", int'(opcode), 'h3);
    check("t6_operand", int'(operand), 'hC);
    check("t6_level", int'(level), 1);
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
